mem_master: RTL and testbench

Bus initiator that drives the shared single-port memory bus (`mem_addr`, bidirectional `mem_data`, `mrd`, `mwr`) on behalf of the core. It accepts one read or write request at a time over a valid/ready handshake and runs the bus cycle with a programmable read wait. It returns one response per request, carrying read data for reads and an acknowledge for writes. It sits between the core's load/store unit and the DRAM model, and is the only agent that drives `mrd`/`mwr`.

---
 rtl/mem_pkg.sv | 5 +
 rtl/mem_master_if.sv | 21 ++
 rtl/defines.sv | 4 +
 rtl/mem_bus_driver.sv | 12 +
 rtl/mem_master.sv | 112 +++++++++++
 tb/tb_mem_master.sv | 239 +++++++++++++++++++++++
 6 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory bus initiator.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ, TURN} mem_master_state_t;
  localparam int RD_WAIT_W = 3;
endpackage

// File: rtl/mem_master_if.sv
// Request/response handshake between the load/store unit and mem_master.
`ifndef MEMORY_SIZE_ENC
`define MEMORY_SIZE_ENC 7
`endif
interface mem_master_if #(
  parameter int ADDR_W = `MEMORY_SIZE_ENC+1,
  parameter int DATA_W = `MEMORY_SIZE_ENC+1
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (output req_valid, req_we, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/defines.sv
// Global memory geometry; bus widths derive from MEMORY_SIZE_ENC.
`ifndef MEMORY_SIZE_ENC
`define MEMORY_SIZE_ENC 7
`endif

// File: rtl/mem_bus_driver.sv
// Tristate driver for the shared mem_data bus: drives when en, always samples.
module mem_bus_driver #(
  parameter int DATA_W = 8
) (
  input  logic              en,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] din,
  inout  wire  [DATA_W-1:0] data
);
  assign data = en ? dout : 'z;
  assign din  = data;
endmodule

// File: rtl/mem_master.sv
// Single-request memory bus initiator with programmable read wait.
// MEM_MASTER_TURNAROUND_EN adds an idle TURN cycle after every read.
`ifndef MEMORY_SIZE_ENC
`define MEMORY_SIZE_ENC 7
`endif
module mem_master
  import mem_pkg::*;
#(
  parameter int ADDR_W  = `MEMORY_SIZE_ENC+1,
  parameter int DATA_W  = `MEMORY_SIZE_ENC+1,
  parameter int RD_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_master_if.slave       bus,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              mrd,
  output logic              mwr
);
  mem_master_state_t    state;
  logic [RD_WAIT_W-1:0] cnt;
  logic [DATA_W-1:0]    wdata_q, rdata_q, din;
  logic                 we_q, ready_q, rsp_q, accept, drv_en;

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_q;
  assign bus.rsp_rdata = rdata_q;
  assign accept        = bus.req_valid && ready_q;
  // Drive only while the write strobe is up so reset releases the bus at once.
  assign drv_en        = mwr && we_q;

  mem_bus_driver #(.DATA_W(DATA_W)) u_drv (
    .en  (drv_en),
    .dout(wdata_q),
    .din (din),
    .data(mem_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      mem_addr <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      ready_q  <= 1'b0;
      rsp_q    <= 1'b0;
      mrd      <= 1'b0;
      mwr      <= 1'b0;
    end else begin
      rsp_q <= 1'b0;
      case (state)
        // WRITE completes in one cycle, so it can take the next request too.
        IDLE, WRITE: begin
          rsp_q <= (state == WRITE);
          if (accept) begin
            mem_addr <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            we_q     <= bus.req_we;
            if (bus.req_we) begin
              state   <= WRITE;
              mwr     <= 1'b1;
              mrd     <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              state   <= READ;
              cnt     <= RD_WAIT_W'(RD_WAIT);
              mrd     <= 1'b1;
              mwr     <= 1'b0;
              ready_q <= 1'b0;
            end
          end else begin
            state   <= IDLE;
            mrd     <= 1'b0;
            mwr     <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        READ: begin
          if (cnt == '0) begin
            rdata_q <= din;
            rsp_q   <= 1'b1;
            mrd     <= 1'b0;
`ifdef MEM_MASTER_TURNAROUND_EN
            state   <= TURN;
            ready_q <= 1'b0;
`else
            state   <= IDLE;
            ready_q <= 1'b1;
`endif
          end else begin
            cnt <= cnt - RD_WAIT_W'(1);
          end
        end
`ifdef MEM_MASTER_TURNAROUND_EN
        TURN: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
`endif
        default: begin
          state   <= IDLE;
          mrd     <= 1'b0;
          mwr     <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: vector table plus multi-cycle corner sequences.
module tb_mem_master;
  localparam int AW = 8;
  localparam int DW = 8;
`ifdef MEM_MASTER_TURNAROUND_EN
  localparam int TURN_READY = 0;
  localparam int TURN_GAP   = 2;
  localparam int HOLD_WAIT  = 1;
`else
  localparam int TURN_READY = 1;
  localparam int TURN_GAP   = 1;
  localparam int HOLD_WAIT  = 0;
`endif

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            lat;
    int            mrdc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus1();
  mem_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus3();
  logic [AW-1:0] mem_addr, mem3_addr;
  wire  [DW-1:0] mem_data, mem3_data;
  logic          mrd, mwr, mrd3, mwr3;

  mem_master #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus1), .mem_addr(mem_addr),
    .mem_data(mem_data), .mrd(mrd), .mwr(mwr)
  );
  mem_master #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .mem_addr(mem3_addr),
    .mem_data(mem3_data), .mrd(mrd3), .mwr(mwr3)
  );

  // DRAM model: erased to 0xFF, drives while mrd; probe drives 0 to expose contention.
  logic [DW-1:0] dram [256];
  logic          probe;
  logic [DW-1:0] dram_q;
  assign dram_q    = probe ? '0 : dram[mem_addr];
  assign mem_data  = (mrd || probe) ? dram_q : 'z;
  assign mem3_data = mrd3 ? 8'hC7 : 'z;

  always @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 256; i++) dram[i] <= 8'hFF;
    else if (mwr) dram[mem_addr] <= mem_data;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready1();
    int n = 0;
    while (!bus1.req_ready && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL ready_timeout: ready %0b want 1", bus1.req_ready);
    end
  endtask

  task automatic send1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus1.req_valid = 1'b1;
    bus1.req_we    = we;
    bus1.req_addr  = a;
    bus1.req_wdata = d;
    wait_ready1();
    tick();
    bus1.req_valid = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    int lat = 0, mrdc = 0, mwrc = 0, ovl = 0;
    logic [DW-1:0] wbus = '0;
    logic [AW-1:0] badr = '0;
    send1(v.we, v.addr, v.we ? v.wdata : 8'hE1);
    while (lat < 30) begin
      if (mrd) mrdc++;
      if (mwr) begin mwrc++; wbus = mem_data; end
      if (mrd || mwr) badr = mem_addr;
      if (mrd && mwr) ovl++;
      if (bus1.rsp_valid) break;
      tick(); lat++;
    end
    chk({tag, "_lat"}, lat, v.lat);
    chk({tag, "_mrd_cycles"}, mrdc, v.mrdc);
    chk({tag, "_mwr_cycles"}, mwrc, v.we ? 1 : 0);
    chk({tag, "_overlap"}, ovl, 0);
    chk({tag, "_addr"}, badr, v.addr);
    chk({tag, "_rdata"}, bus1.rsp_rdata, v.rdata);
    if (v.we) chk({tag, "_wbus"}, wbus, v.wdata);
  endtask

  vec_t vt[11];

  initial begin
    int n, lat, mrdc, early, ovl3, nrsp;
    bus1.req_valid = 0; bus1.req_we = 0; bus1.req_addr = '0; bus1.req_wdata = '0;
    bus3.req_valid = 0; bus3.req_we = 0; bus3.req_addr = '0; bus3.req_wdata = '0;
    probe = 1'b1;

    vt[0]  = '{1'b1, 8'h03, 8'h05, 8'h00, 1, 0};
    vt[1]  = '{1'b0, 8'h03, 8'h00, 8'h05, 2, 2};
    vt[2]  = '{1'b0, 8'h10, 8'h00, 8'hFF, 2, 2};
    vt[3]  = '{1'b1, 8'h07, 8'hA5, 8'hFF, 1, 0};
    vt[4]  = '{1'b0, 8'h07, 8'h00, 8'hA5, 2, 2};
    vt[5]  = '{1'b1, 8'h00, 8'h00, 8'hA5, 1, 0};
    vt[6]  = '{1'b1, 8'hFF, 8'h5A, 8'hA5, 1, 0};
    vt[7]  = '{1'b0, 8'hFF, 8'h00, 8'h5A, 2, 2};
    vt[8]  = '{1'b0, 8'h00, 8'h00, 8'h00, 2, 2};
    vt[9]  = '{1'b1, 8'h07, 8'h3C, 8'h00, 1, 0};
    vt[10] = '{1'b0, 8'h07, 8'h00, 8'h3C, 2, 2};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mrd", mrd, 0);
    chk("rst_mwr", mwr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rsp_valid", bus1.rsp_valid, 0);
    chk("rst_rsp_rdata", bus1.rsp_rdata, 0);
    chk("rst_req_ready", bus1.req_ready, 0);
    chk("rst_bus_released", mem_data, 0);
    @(negedge clk);
    rst = 1'b0; probe = 1'b0;
    tick();
    chk("ready_after_rst", bus1.req_ready, 1);

    for (int i = 0; i < 11; i++) apply(vt[i], $sformatf("v%0d", i));

    // Back-to-back writes: second accepted while the first is on the bus.
    wait_ready1();
    bus1.req_valid = 1; bus1.req_we = 1; bus1.req_addr = 8'h20; bus1.req_wdata = 8'h11;
    tick();
    chk("b2b_ready_in_write", bus1.req_ready, 1);
    chk("b2b_mwr1", mwr, 1);
    chk("b2b_bus1", mem_data, 8'h11);
    bus1.req_addr = 8'h21; bus1.req_wdata = 8'h22;
    tick();
    chk("b2b_rsp1", bus1.rsp_valid, 1);
    chk("b2b_mwr2", mwr, 1);
    chk("b2b_addr2", mem_addr, 8'h21);
    chk("b2b_bus2", mem_data, 8'h22);
    bus1.req_valid = 0;
    tick();
    chk("b2b_rsp2", bus1.rsp_valid, 1);
    chk("b2b_mwr_off", mwr, 0);
    apply('{1'b0, 8'h20, 8'h00, 8'h11, 2, 2}, "b2b_rd20");
    apply('{1'b0, 8'h21, 8'h00, 8'h22, 2, 2}, "b2b_rd21");

    // Read followed by write: turnaround gap and bus release after the response.
    wait_ready1();
    send1(1'b0, 8'h07, 8'hE1);
    n = 0;
    while (!bus1.rsp_valid && n < 20) begin tick(); n++; end
    chk("rw_rdata", bus1.rsp_rdata, 8'h3C);
    probe = 1'b1;
    #1;
    chk("rw_after_rsp_bus_z", mem_data, 0);
    chk("rw_after_rsp_ready", bus1.req_ready, TURN_READY);
    chk("rw_after_rsp_mwr", mwr, 0);
    probe = 1'b0;
    bus1.req_valid = 1; bus1.req_we = 1; bus1.req_addr = 8'h08; bus1.req_wdata = 8'h99;
    n = 0;
    while (!mwr && n < 10) begin tick(); n++; end
    chk("rw_write_gap", n, TURN_GAP);
    chk("rw_write_bus", mem_data, 8'h99);
    bus1.req_valid = 0;
    tick();
    chk("rw_write_rsp", bus1.rsp_valid, 1);

    // RD_WAIT=3 with valid held: one accept, then the next only from IDLE.
    bus3.req_valid = 1; bus3.req_we = 0; bus3.req_addr = 8'h05; bus3.req_wdata = 8'h00;
    n = 0;
    while (!bus3.req_ready && n < 20) begin tick(); n++; end
    tick();
    chk("hold_addr", mem3_addr, 8'h05);
    lat = 0; mrdc = 0; early = 0; ovl3 = 0;
    while (!bus3.rsp_valid && lat < 30) begin
      if (mrd3) mrdc++;
      if (mrd3 && mwr3) ovl3++;
      if (bus3.req_ready) early++;
      tick(); lat++;
    end
    chk("hold_mrd_cycles", mrdc, 4);
    chk("hold_lat", lat, 4);
    chk("hold_no_early_accept", early, 0);
    chk("hold_overlap", ovl3, 0);
    chk("hold_rdata", bus3.rsp_rdata, 8'hC7);
    n = 0;
    while (!bus3.req_ready && n < 10) begin tick(); n++; end
    chk("hold_idle_wait", n, HOLD_WAIT);
    tick();
    chk("hold_second_accept", mrd3, 1);
    bus3.req_valid = 0;
    n = 0;
    while (!bus3.rsp_valid && n < 20) begin tick(); n++; end
    chk("hold_second_rsp", bus3.rsp_valid, 1);

    // Reset in the middle of a read: strobe drops without a clock edge.
    wait_ready1();
    send1(1'b0, 8'h10, 8'h00);
    chk("midrd_mrd_before", mrd, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrd_mrd_async", mrd, 0);
    chk("midrd_mwr_async", mwr, 0);
    chk("midrd_rsp_async", bus1.rsp_valid, 0);
    chk("midrd_ready_async", bus1.req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    nrsp = 0;
    repeat (4) begin tick(); if (bus1.rsp_valid) nrsp++; end
    chk("midrd_no_rsp", nrsp, 0);
    chk("midrd_rdata_reset", bus1.rsp_rdata, 0);
    apply('{1'b1, 8'h01, 8'h77, 8'h00, 1, 0}, "post_rst_wr");
    apply('{1'b0, 8'h01, 8'h00, 8'h77, 2, 2}, "post_rst_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
